// File: rtl/out_sat_serializer.sv
// rtl/out_sat_serializer.sv - round/saturate a stereo accumulator pair and shift it out MSB first
`timescale 1ns/1ps

module out_sat_serializer #(
    parameter int ACC_W   = 40,
    parameter int OUT_W   = 16,
    parameter int LSB_POS = 16
) (
    input  logic             Sclk,
    input  logic             Reset,
    input  logic             load,
    input  logic [ACC_W-1:0] accL,
    input  logic [ACC_W-1:0] accR,
    output logic             ready,
    output logic             Frame,
    output logic             Dout,
    output logic [OUT_W-1:0] sampleL,
    output logic [OUT_W-1:0] sampleR,
    output logic             satL,
    output logic             satR,
    output logic             ovr
);

    // Holding registers keep only the bits that can influence the result:
    // the sample field and above, plus the rounding bit just below it.
    localparam int HOLD_W = ACC_W - LSB_POS + 1;
    localparam int SH_W   = 2 * OUT_W;
    localparam int CNT_W  = $clog2(SH_W);

    typedef enum logic [1:0] {IDLE, CONV, SHIFT} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SH_W-1:0]   sh_q, sh_d;
    logic [HOLD_W-1:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d;
    logic [OUT_W-1:0]  sample_l_q, sample_l_d, sample_r_q, sample_r_d;
    logic              sat_l_q, sat_l_d, sat_r_q, sat_r_d;
    logic              ovr_q, ovr_d;
    logic [OUT_W:0]    conv_l, conv_r;
    logic              unused_low;

    assign unused_low = ^{accL[LSB_POS-2:0], accR[LSB_POS-2:0]};

    // Returns {sat, sample}. Adding the rounding bit to the sign-extended upper
    // field is the same as adding 2^(LSB_POS-1) to the full accumulator.
    function automatic logic [OUT_W:0] convert(input logic [HOLD_W-1:0] h);
        logic [HOLD_W-1:0] r;
        r = {h[HOLD_W-1], h[HOLD_W-1:1]} + HOLD_W'(h[0]);
        if ((&r[HOLD_W-1:OUT_W-1]) || !(|r[HOLD_W-1:OUT_W-1]))
            convert = {1'b0, r[OUT_W-1:0]};
        else
            convert = {1'b1, h[HOLD_W-1], {(OUT_W-1){~h[HOLD_W-1]}}};
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sh_d       = sh_q;
        acc_l_d    = acc_l_q;
        acc_r_d    = acc_r_q;
        sample_l_d = sample_l_q;
        sample_r_d = sample_r_q;
        sat_l_d    = sat_l_q;
        sat_r_d    = sat_r_q;
        ovr_d      = ovr_q | (load & (state_q != IDLE));
        ready      = 1'b0;
        Frame      = 1'b0;
        Dout       = 1'b0;
        conv_l     = convert(acc_l_q);
        conv_r     = convert(acc_r_q);
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (load) begin
                    acc_l_d = accL[ACC_W-1:LSB_POS-1];
                    acc_r_d = accR[ACC_W-1:LSB_POS-1];
                    state_d = CONV;
                end
            end
            CONV: begin
                sample_l_d = conv_l[OUT_W-1:0];
                sample_r_d = conv_r[OUT_W-1:0];
                sat_l_d    = conv_l[OUT_W];
                sat_r_d    = conv_r[OUT_W];
                sh_d       = {conv_l[OUT_W-1:0], conv_r[OUT_W-1:0]};
                cnt_d      = '0;
                state_d    = SHIFT;
            end
            SHIFT: begin
                Dout  = sh_q[SH_W-1];
                Frame = (cnt_q == '0);
                sh_d  = {sh_q[SH_W-2:0], 1'b0};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(SH_W - 1))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Sclk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sh_q       <= '0;
            acc_l_q    <= '0;
            acc_r_q    <= '0;
            sample_l_q <= '0;
            sample_r_q <= '0;
            sat_l_q    <= 1'b0;
            sat_r_q    <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            acc_l_q    <= acc_l_d;
            acc_r_q    <= acc_r_d;
            sample_l_q <= sample_l_d;
            sample_r_q <= sample_r_d;
            sat_l_q    <= sat_l_d;
            sat_r_q    <= sat_r_d;
            ovr_q      <= ovr_d;
        end
    end

    assign sampleL = sample_l_q;
    assign sampleR = sample_r_q;
    assign satL    = sat_l_q;
    assign satR    = sat_r_q;
    assign ovr     = ovr_q;

endmodule

// File: tb/tb_out_sat_serializer.sv
// tb/tb_out_sat_serializer.sv - self-checking bench for out_sat_serializer
`timescale 1ns/1ps

module tb_out_sat_serializer;

    logic        Sclk = 1'b0;
    logic        Reset, load;
    logic [39:0] accL, accR;
    logic        ready, Frame, Dout, satL, satR, ovr;
    logic [15:0] sampleL, sampleR;

    int   n_assert = 0;
    int   n_fail   = 0;
    int   fno      = 0;
    logic ovr_exp  = 1'b0;

    always #5 Sclk = ~Sclk;

    out_sat_serializer #(.ACC_W(40), .OUT_W(16), .LSB_POS(16)) dut (
        .Sclk(Sclk), .Reset(Reset), .load(load), .accL(accL), .accR(accR),
        .ready(ready), .Frame(Frame), .Dout(Dout), .sampleL(sampleL),
        .sampleR(sampleR), .satL(satL), .satR(satR), .ovr(ovr)
    );

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Sclk);
        #1;
    endtask

    // Reference: floor((acc + 2^15) / 2^16) on the true integer, then clamp.
    function automatic logic [16:0] ref_conv(input logic [39:0] acc);
        longint a, q;
        a = $signed(acc);
        q = (a + 64'sd32768) >>> 16;
        if (q > 64'sd32767)       ref_conv = {1'b1, 16'h7FFF};
        else if (q < -64'sd32768) ref_conv = {1'b1, 16'h8000};
        else                      ref_conv = {1'b0, q[15:0]};
    endfunction

    function automatic logic [39:0] rand_acc();
        logic [63:0] v;
        longint      s;
        v = {$urandom, $urandom};
        s = $signed(v[39:0]);
        s = s >>> $urandom_range(0, 24);
        rand_acc = s[39:0];
    endfunction

    // Entered in an IDLE cycle; returns in the cycle ready comes back (cycle 34).
    task automatic do_frame(input logic [39:0] l, input logic [39:0] r,
                            input int pulse_cyc, input bit b2b);
        logic [16:0] el, er;
        logic [31:0] stream;
        int          frames;
        fno++;
        el = ref_conv(l);
        er = ref_conv(r);
        chk($sformatf("f%0d_ready_idle", fno), {39'd0, ready}, 40'd1);
        load   = 1'b1;
        accL   = l;
        accR   = r;
        stream = '0;
        frames = 0;
        if (pulse_cyc > 0 || b2b) ovr_exp = 1'b1;
        for (int cyc = 1; cyc <= 34; cyc++) begin
            tick();
            if (b2b) begin
                accL = rand_acc();
                accR = rand_acc();
            end else begin
                load = (cyc == pulse_cyc);
                if (cyc == pulse_cyc) begin
                    accL = rand_acc();
                    accR = rand_acc();
                end
            end
            if (cyc == 1)
                chk($sformatf("f%0d_ready_conv", fno), {39'd0, ready}, 40'd0);
            if (cyc == 2) begin
                chk($sformatf("f%0d_frame_first", fno), {39'd0, Frame}, 40'd1);
                chk($sformatf("f%0d_sampleL", fno), {24'd0, sampleL}, {24'd0, el[15:0]});
                chk($sformatf("f%0d_sampleR", fno), {24'd0, sampleR}, {24'd0, er[15:0]});
                chk($sformatf("f%0d_satL", fno), {39'd0, satL}, {39'd0, el[16]});
                chk($sformatf("f%0d_satR", fno), {39'd0, satR}, {39'd0, er[16]});
            end
            if (cyc >= 2 && cyc <= 33) begin
                stream = {stream[30:0], Dout};
                frames += int'(Frame);
            end
        end
        chk($sformatf("f%0d_stream", fno), {8'd0, stream}, {8'd0, el[15:0], er[15:0]});
        chk($sformatf("f%0d_frame_count", fno), 40'(frames), 40'd1);
        chk($sformatf("f%0d_ready_back", fno), {39'd0, ready}, 40'd1);
        chk($sformatf("f%0d_dout_idle", fno), {39'd0, Dout}, 40'd0);
        chk($sformatf("f%0d_ovr", fno), {39'd0, ovr}, {39'd0, ovr_exp});
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dout"},    {39'd0, Dout},    40'd0);
        chk({tag, "_frame"},   {39'd0, Frame},   40'd0);
        chk({tag, "_sampleL"}, {24'd0, sampleL}, 40'd0);
        chk({tag, "_sampleR"}, {24'd0, sampleR}, 40'd0);
        chk({tag, "_satL"},    {39'd0, satL},    40'd0);
        chk({tag, "_satR"},    {39'd0, satR},    40'd0);
        chk({tag, "_ovr"},     {39'd0, ovr},     40'd0);
        chk({tag, "_ready"},   {39'd0, ready},   40'd1);
    endtask

    initial begin
        Reset = 1'b1;
        load  = 1'b0;
        accL  = '0;
        accR  = '0;
        tick();
        tick();
        chk_all_zero("reset");
        Reset = 1'b0;
        tick();

        do_frame(40'h0012340000, 40'hFFEDCC0000, 0, 1'b0);
        do_frame(40'h0012348000, 40'hFFFFFF8000, 0, 1'b0);
        do_frame(40'h0012347FFF, 40'h0000000000, 0, 1'b0);
        do_frame(40'h0100000000, 40'hF000000000, 0, 1'b0);
        do_frame(40'h007FFF8000, 40'hFF80000000, 0, 1'b0);
        do_frame(40'h7FFFFFFFFF, 40'h8000000000, 0, 1'b0);

        // Round trip: sign-extended 16-bit samples must come back unchanged.
        for (int i = 0; i < 3; i++) begin
            logic [15:0] xl, xr;
            xl = 16'($urandom);
            xr = 16'($urandom);
            do_frame({{8{xl[15]}}, xl, 16'h0000}, {{8{xr[15]}}, xr, 16'h0000}, 0, 1'b0);
        end
        for (int i = 0; i < 4; i++) do_frame(rand_acc(), rand_acc(), 0, 1'b0);

        do_frame(rand_acc(), rand_acc(), 10, 1'b0);
        do_frame(rand_acc(), rand_acc(), 0, 1'b0);

        // Abort a transfer mid-shift with an asynchronous reset.
        load = 1'b1;
        accL = 40'h007FFF0000;
        accR = 40'hFF80000000;
        tick();
        load = 1'b0;
        repeat (14) tick();
        #2 Reset = 1'b1;
        #1;
        chk_all_zero("midreset");
        ovr_exp = 1'b0;
        @(posedge Sclk);
        #1 Reset = 1'b0;
        tick();
        do_frame(rand_acc(), rand_acc(), 0, 1'b0);

        for (int i = 0; i < 3; i++) do_frame(rand_acc(), rand_acc(), 0, 1'b1);
        load = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/out_sat_serializer.md
Name: out_sat_serializer

Overview:
- Output-side counterpart of the input sign-extension stage.
- Accepts one stereo pair of 40-bit accumulator results (Q8.32 framing: integer sample field at [31:16], guard bits [39:32], fraction [15:0]).
- Rounds and saturates each channel back to a 16-bit sample, then shifts the pair out serially, MSB first, left then right, with a one-cycle frame pulse.
- Sits between the MAC/filter datapath and the output serial pin, clocked on Sclk.

Parameters:
- ACC_W, 40, accumulator width.
- OUT_W, 16, output sample width.
- LSB_POS, 16, bit position of the sample LSB inside the accumulator.

Ports:
- Sclk, input, 1, system/serial clock; all state changes on the rising edge.
- Reset, input, 1, asynchronous, active-high reset.
- load, input, 1, request to accept accL/accR this cycle.
- accL, input, 40, left accumulator result, two's complement.
- accR, input, 40, right accumulator result, two's complement.
- ready, output, 1, high only in IDLE; combinational from state.
- Frame, output, 1, high for exactly one cycle, coincident with bit L[15] on Dout.
- Dout, output, 1, serial data.
- sampleL, output, 16, registered converted left sample.
- sampleR, output, 16, registered converted right sample.
- satL, output, 1, left channel saturated in the last conversion.
- satR, output, 1, right channel saturated in the last conversion.
- ovr, output, 1, sticky: load asserted while not ready; cleared only by Reset.

Behaviour:
- Reset value (asynchronous, immediate):
  - state IDLE, bit counter 0, shift register 0.
  - Dout=0, Frame=0, sampleL=sampleR=0, satL=satR=0, ovr=0.
- States: IDLE -> CONV -> SHIFT -> IDLE.
- IDLE:
  - Dout=0, Frame=0.
  - On an edge with load=1, capture accL/accR into holding registers and go to CONV.
- CONV (1 cycle), per channel:
  - Round half-up: sum = acc + 2^(LSB_POS-1), computed at 41 bits.
  - Saturation test: if sum[39:31] is not all-equal, or the 41-bit sum overflowed, saturate.
  - Saturated result: 0x7FFF if acc[39]=0, else 0x8000.
  - Otherwise result = sum[31:16].
  - Register the results into sampleL/sampleR and satL/satR.
  - Load the 32-bit shift register with {sampleL, sampleR}.
  - Go to SHIFT.
- SHIFT (32 cycles):
  - Dout = shift register MSB; shift left one bit per cycle.
  - Frame=1 only on the first SHIFT cycle.
  - Counter runs 0..31; after bit 31 go to IDLE.
- Latency: load edge at cycle 0; L[15] on Dout during cycle 2; R[0] during cycle 33; ready=1 again at cycle 34. Minimum frame period is 34 cycles.
- load while not ready (CONV or SHIFT):
  - Ignored: data is not captured and the current frame is unaffected.
  - Sets ovr=1.
- load and ready at the same edge: accepted normally; ovr unchanged.
- sampleL/sampleR/satL/satR hold their values until the next CONV.
- Reset mid-SHIFT: transfer aborts; the next frame starts cleanly from IDLE.
- Round-trip property: an accumulator produced by input sign-extension of x (x at [31:16], low bits 0) converts back to exactly x, with sat=0.

Test Plan:
- Reset, then load accL=0x0012340000, accR=0xFFEDCC0000 -> sampleL=0x1234, sampleR=0xEDCC, sat=0; Frame high in cycle 2; Dout over 32 cycles = 0x1234EDCC MSB-first; ready returns at cycle 34.
- Rounding: accL=0x0012348000 -> 0x1235; accL=0x0012347FFF -> 0x1234; accR=0xFFFFFF8000 -> 0x0000, satR=0.
- Saturation: accL=0x0100000000 -> 0x7FFF, satL=1; accR=0xF000000000 -> 0x8000, satR=1; accL=0x007FFF8000 (rounding overflow) -> 0x7FFF, satL=1; accR=0xFF80000000 -> 0x8000, satR=0.
- Overrun: pulse load again at cycle 10 with different data -> output stream unchanged, ovr=1; next load after ready is accepted; ovr stays 1.
- Reset asserted at cycle 15 mid-shift -> Dout, Frame and all outputs 0 immediately; ready=1 after release; a new load produces a full, correct frame.
- Back-to-back: load held high continuously with changing data -> frames accepted every 34 cycles; each frame carries the data present at its accept edge; exactly one Frame pulse per frame.
